// File: rtl/spindle_feedback_monitor.sv
// spindle_feedback_monitor
//
// Closed-loop feedback monitor for the lathe spindle run command. It measures
// spindle speed over a fixed gate window and checks three things: the spindle
// starts when commanded, keeps running while commanded, and stops when released.
// If any check fails, it latches a fault and asserts the run interlock (inhibit).
//
// Optional feature macro: FB_GLITCH_FILTER_EN
//   When defined, the synchronized feedback level must be stable for
//   3 consecutive samples before it is accepted. Edge latency becomes
//   4 cycles, and pulses shorter than 3 cycles are rejected.
//   When undefined, there is no filter and edge latency is 2 cycles.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   ena          in   clock enable; 0 freezes all state
//   cmd_run      in   spindle run command from the controller
//   fb_pulse     in   raw asynchronous hall/encoder pulse
//   clear_fault  in   fault acknowledge (honoured only with cmd_run low)
//   running      out  high in RUN
//   fault        out  high in FAULT
//   inhibit      out  copy of fault; gates the controller's run output
//   fault_code   out  0 none, 1 no spin-up, 2 stall, 3 unexpected/overrun motion
//   speed        out  pulse count of the last completed window, saturating at 255
//   speed_valid  out  one-cycle strobe when speed updates
//   state        out  IDLE=0, SPINUP=1, RUN=2, SPINDOWN=3, FAULT=4

module spindle_feedback_monitor #(
    parameter int unsigned GATE_CYCLES  = 50_000,
    parameter int unsigned ACK_TIMEOUT  = 100_000_000,
    parameter int unsigned STOP_TIMEOUT = 250_000_000,
    parameter int unsigned MIN_PULSES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       cmd_run,
    input  logic       fb_pulse,
    input  logic       clear_fault,
    output logic       running,
    output logic       fault,
    output logic       inhibit,
    output logic [1:0] fault_code,
    output logic [7:0] speed,
    output logic       speed_valid,
    output logic [2:0] state
);

    localparam int unsigned GateW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned TimerMax = (ACK_TIMEOUT > STOP_TIMEOUT) ? ACK_TIMEOUT : STOP_TIMEOUT;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    localparam logic [GateW-1:0]  GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [TimerW-1:0] AckLast  = TimerW'(ACK_TIMEOUT - 1);
    localparam logic [TimerW-1:0] StopLast = TimerW'(STOP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StSpinup   = 3'd1,
        StRun      = 3'd2,
        StSpindown = 3'd3,
        StFault    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         code_q, code_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [GateW-1:0]   gate_q;
    logic [7:0]         pulse_cnt_q;
    logic [7:0]         speed_q;
    logic               speed_valid_q;
    logic               sync1_q, sync2_q;
    logic               pulse_edge;
    logic [7:0]         win_count;
    logic               gate_end;
    logic               win_moving;

    // ------------------------------------------------------------------
    // Feedback input path: 2-flop synchronizer, optional filter, edge detect
    // ------------------------------------------------------------------
`ifdef FB_GLITCH_FILTER_EN
    logic hist1_q, hist2_q, filt_q;

    // Accept a new level only after sync2, hist1 and hist2 all agree on it.
    // The rising edge is counted on the same edge that updates filt_q.
    assign pulse_edge = sync2_q & hist1_q & hist2_q & ~filt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else if (ena) begin
            sync1_q <= fb_pulse;
            sync2_q <= sync1_q;
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) begin
                filt_q <= sync2_q;
            end
        end
    end
`else
    logic prev_q;

    assign pulse_edge = sync2_q & ~prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else if (ena) begin
            sync1_q <= fb_pulse;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Gate window and pulse counting
    // ------------------------------------------------------------------
    // The window total includes any edge that lands in the gate-end cycle itself.
    assign win_count  = (pulse_cnt_q == 8'hFF) ? 8'hFF : pulse_cnt_q + {7'd0, pulse_edge};
    assign gate_end   = (gate_q == GateLast);
    assign win_moving = ({24'd0, win_count} >= 32'(MIN_PULSES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_q        <= '0;
            pulse_cnt_q   <= 8'd0;
            speed_q       <= 8'd0;
            speed_valid_q <= 1'b0;
        end else if (ena) begin
            gate_q        <= gate_end ? '0 : gate_q + GateW'(1);
            pulse_cnt_q   <= gate_end ? 8'd0 : win_count;
            speed_valid_q <= gate_end;
            if (gate_end) begin
                speed_q <= win_count;
            end
        end else begin
            // A frozen strobe would otherwise read as repeated updates.
            speed_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            code_q  <= 2'd0;
            timer_q <= '0;
        end else if (ena) begin
            state_q <= state_d;
            code_q  <= code_d;
            timer_q <= timer_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (priority follows branch order inside each state)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                if (gate_end && win_moving) begin
                    state_d = StFault;
                    code_d  = 2'd3;
                end else if (cmd_run) begin
                    state_d = StSpinup;
                end
            end
            StSpinup: begin
                if (!cmd_run) begin
                    state_d = StSpindown;
                end else if (gate_end && win_moving) begin
                    state_d = StRun;
                end else if (timer_q == AckLast) begin
                    state_d = StFault;
                    code_d  = 2'd1;
                end
            end
            StRun: begin
                if (!cmd_run) begin
                    state_d = StSpindown;
                end else if (gate_end && !win_moving) begin
                    state_d = StFault;
                    code_d  = 2'd2;
                end
            end
            StSpindown: begin
                if (cmd_run) begin
                    state_d = StSpinup;
                end else if (gate_end && !win_moving) begin
                    state_d = StIdle;
                end else if (timer_q == StopLast) begin
                    state_d = StFault;
                    code_d  = 2'd3;
                end
            end
            StFault: begin
                if (clear_fault && !cmd_run) begin
                    state_d = StIdle;
                    code_d  = 2'd0;
                end
            end
            default: begin
                state_d = StIdle;
                code_d  = 2'd0;
            end
        endcase
        // The timer restarts on every state entry.
        timer_d = (state_d != state_q) ? '0 : timer_q + TimerW'(1);
    end

    // ------------------------------------------------------------------
    // FSM: outputs (all derived from registers)
    // ------------------------------------------------------------------
    always_comb begin
        running     = (state_q == StRun);
        fault       = (state_q == StFault);
        inhibit     = (state_q == StFault);
        fault_code  = code_q;
        speed       = speed_q;
        speed_valid = speed_valid_q;
        state       = state_q;
    end

endmodule
